rr_grant_arbiter: RTL
=====================

// Module: rr_grant_arbiter
// PURPOSE
//   Parametrised round-robin arbiter for the AXI-Lite interconnect master side.
//   Successor to the free-running master counter: grants only to requesting
//   masters, skips idle ones, locks the grant until the transaction completes.
//   Sits between the master request lines and the interconnect address/data muxes.
// PARAMETERS
//   NUM_MASTERS  4   number of requesting masters (>=2)
//   MAX_HOLD     16  cycles a grant may be held before forced release (ARB_TIMEOUT_EN only)
// PORTS
//   clk_i          in   1            system clock, rising edge
//   resetn_i       in   1            asynchronous reset, active low
//   req_i          in   NUM_MASTERS  per-master request, level
//   done_i         in   1            single-cycle pulse: granted transaction finished
//   grant_o        out  NUM_MASTERS  one-hot grant, registered
//   grant_idx_o    out  IDX_W        binary index of granted master, IDX_W=$clog2(NUM_MASTERS)
//   grant_valid_o  out  1            a grant is active
//   timeout_o      out  1            one-cycle pulse on forced release
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, ptr=0, grant_o=0,
//     grant_idx_o=0, grant_valid_o=0, timeout_o=0, hold counter=0.
//   FSM states: IDLE, BUSY.
//   IDLE: if |req_i, select first set bit scanning ptr, ptr+1, ... mod NUM_MASTERS;
//     next edge: BUSY, grant_o/grant_idx_o/grant_valid_o updated. Latency req->grant
//     = 1 cycle. No req: stay IDLE, outputs zero.
//   BUSY: grant frozen regardless of req_i (dropped req does not revoke grant).
//     done_i=1 -> next edge IDLE, grant outputs cleared, ptr = granted idx + 1,
//     wrapping NUM_MASTERS-1 -> 0. Minimum one IDLE bubble between grants.
//   done_i in IDLE ignored. done_i together with new reqs in BUSY: release first;
//     the new arbitration happens in the following IDLE cycle with the updated ptr.
//   Fairness: a continuously requesting master waits at most NUM_MASTERS-1 grants.
//   Reset mid-BUSY: grant dropped immediately (async); ptr returns to 0.
//   grant_idx_o always equals the encoded grant_o; both zero when grant_valid_o=0.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: hold counter starts at 0 on entry to BUSY, increments
//     each BUSY cycle; if it reaches MAX_HOLD-1 with no done_i, next edge -> IDLE,
//     ptr advanced as for done, timeout_o pulses 1 cycle. done_i on the same cycle
//     takes precedence (normal release, no timeout_o).
//   Not defined: no counter logic; grant held indefinitely; timeout_o tied 0.
// STRUCTURE
//   Package axil_arb_pkg: FSM state encoding (IDLE=0, BUSY=1), IDX_W helper
//     function, shared with future read/write-channel arbiters.
//   Sub-module rr_priority_select: combinational rotate-by-ptr, find-first-set,
//     rotate back; outputs one-hot pick and binary index. Top holds FSM/ptr/counter.
// TESTING
//   Reset: resetn_i=0 with req_i=4'b1111 -> all outputs 0; release -> grant_o=0001
//     one cycle later.
//   Rotation: req_i=4'b1111 held, done_i pulsed 2 cycles after each grant ->
//     grant_idx_o sequence 0,1,2,3,0 with one idle cycle between grants.
//   Skip idle: req_i=4'b1010, ptr=0 -> grant 1, then after done grant 3, then 1.
//   Lock: grant on master 2, drop req_i[2] and raise req_i[0] -> grant_o stays 0100
//     until done_i; then grant 0001.
//   Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): grant held with no done_i -> release
//     after 16 BUSY cycles, timeout_o high exactly 1 cycle, next requester granted;
//     without macro grant persists 100+ cycles, timeout_o never asserts.
//   Async reset mid-BUSY: resetn_i low between edges -> grant_valid_o falls at once.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared definitions for the AXI-Lite interconnect arbiters.
//   arb_state_e : arbiter FSM encoding (StIdle=0, StBusy=1)
//   idx_w()     : width of a binary index into n items (at least 1 bit)
package axil_arb_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the masters and the round-robin arbiter.
//   req         per-master level request
//   done        one-cycle pulse: granted transaction finished
//   grant       one-hot grant
//   grant_idx   binary index of the granted master
//   grant_valid a grant is active
//   timeout     one-cycle pulse on forced release
// Modports: master (request side), slave (arbiter side).
interface rr_grant_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  import axil_arb_pkg::*;

  localparam int unsigned IDX_W = idx_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic                   done;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic                   timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: rotate requests so ptr_i lands on bit 0,
// find the first set bit, then rotate the result back.
//   req_i      per-master requests
//   ptr_i      highest-priority master index (must be < NUM_MASTERS)
//   pick_o     one-hot selected master (zero when no request)
//   pick_idx_o binary index of pick_o (zero when no request)
//   any_o      at least one request present
module rr_priority_select
  import axil_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  localparam int unsigned IDX_W = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] pick_o,
  output logic [IDX_W-1:0]       pick_idx_o,
  output logic                   any_o
);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [IDX_W-1:0]         first_idx;
  logic                     found;
  logic [IDX_W:0]           sum;

  // Doubling the vector turns the rotate into a plain part-select.
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[ptr_i +: NUM_MASTERS];

  always_comb begin
    found     = 1'b0;
    first_idx = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (!found && req_rot[i]) begin
        found     = 1'b1;
        first_idx = IDX_W'(i);
      end
    end
  end

  // Rotate back: (ptr + first) mod NUM_MASTERS, valid for non-power-of-two counts.
  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, first_idx};
    if (sum >= (IDX_W+1)'(NUM_MASTERS)) begin
      sum = sum - (IDX_W+1)'(NUM_MASTERS);
    end
  end

  assign any_o      = found;
  assign pick_idx_o = found ? sum[IDX_W-1:0] : '0;
  assign pick_o     = found ? (NUM_MASTERS'(1) << sum[IDX_W-1:0]) : '0;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter for the AXI-Lite interconnect master side.
// Grants only requesting masters, starting the scan at ptr; the grant is
// locked until done, after which ptr moves to the master after the winner.
// One IDLE bubble always separates consecutive grants.
//   clk_i     system clock, rising edge
//   resetn_i  asynchronous reset, active low
//   bus_io    rr_grant_arbiter_if.slave (req/done in, grant/idx/valid/timeout out)
// Build option: define ARB_TIMEOUT_EN to force release after MAX_HOLD BUSY
// cycles without done (timeout pulses one cycle); otherwise timeout is tied 0.
module rr_grant_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  rr_grant_arbiter_if.slave bus_io
);

  localparam int unsigned IDX_W = idx_w(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       ptr_after_grant;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  rr_priority_select #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_select (
    .req_i     (bus_io.req),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .pick_idx_o(pick_idx),
    .any_o     (pick_any)
  );

  assign ptr_after_grant = (idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = idx_w(MAX_HOLD);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD != 0);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StBusy;
          grant_d = pick;
          idx_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      StBusy: begin
        // done wins over a simultaneous timeout.
        if (bus_io.done) begin
          state_d = StIdle;
          grant_d = '0;
          idx_d   = '0;
          ptr_d   = ptr_after_grant;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = StIdle;
          grant_d   = '0;
          idx_d     = '0;
          ptr_d     = ptr_after_grant;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_io.timeout = timeout_q;
`else
  assign bus_io.timeout = 1'b0;
`endif

  assign bus_io.grant       = grant_q;
  assign bus_io.grant_idx   = idx_q;
  assign bus_io.grant_valid = (state_q == StBusy);

endmodule
